// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed single-MAC FIR filter with writable taps,
// round-half-up output scaling and saturation.
module fir_mac_seq #(
    parameter int NTAPS = 17,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 8,
    parameter int SHIFT = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DW-1:0]       data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_i,
    output logic signed [OW-1:0]       data_o,
    output logic                       valid_o,
    output logic                       sat_o,
    output logic                       drop_o
);
    localparam int AW   = $clog2(NTAPS);
    localparam int AccW = DW + CW + AW;
    localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [AccW:0] RND  = (SHIFT > 0) ? (AccW + 1)'(1) << RS : '0;
    localparam logic signed [AccW:0] OMAX = {{(AccW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AccW:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   x_q [NTAPS];
    logic signed [DW-1:0]   x_d [NTAPS];
    logic signed [CW-1:0]   c_q [NTAPS];
    logic signed [CW-1:0]   c_d [NTAPS];
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [AW-1:0]          k_q, k_d;
    logic signed [OW-1:0]   data_q, data_d;
    logic                   valid_q, valid_d, sat_q, sat_d, drop_q, drop_d;
    logic signed [DW+CW-1:0] prod;
    logic signed [AccW:0]   rnd;

    assign ready_o = (state_q == IDLE);
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sat_o   = sat_q;
    assign drop_o  = drop_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        c_d     = c_q;
        acc_d   = acc_q;
        k_d     = k_q;
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        drop_d  = valid_i && (state_q != IDLE);
        prod    = x_q[k_q] * c_q[k_q];
        // one extra bit keeps the rounding add from wrapping at full-scale acc
        rnd     = ($signed({acc_q[AccW-1], acc_q}) + RND) >>> SHIFT;
        if (state_q == IDLE && coef_we && 32'(coef_addr) < NTAPS)
            c_d[coef_addr] = coef_i;
        case (state_q)
            IDLE: if (valid_i) begin
                x_d[0] = data_i;
                for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + {{AW{prod[DW+CW-1]}}, prod};
                k_d   = k_q + 1'b1;
                if (32'(k_q) == NTAPS - 1) state_d = DONE;
            end
            DONE: begin
                valid_d = 1'b1;
                sat_d   = (rnd > OMAX) || (rnd < OMIN);
                data_d  = (rnd > OMAX) ? OMAX[OW-1:0] : (rnd < OMIN) ? OMIN[OW-1:0] : rnd[OW-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '{default: '0};
            c_q     <= '{default: '0};
            acc_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed checks of impulse response, timing, saturation,
// dropped samples, coefficient write guards and mid-operation reset.
module tb_fir_mac_seq;
    logic              clk;
    logic              rst;
    logic signed [7:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              coef_we;
    logic [4:0]        coef_addr;
    logic signed [7:0] coef_i;
    logic signed [7:0] data_o;
    logic              valid_o;
    logic              sat_o;
    logic              drop_o;

    int checks = 0;
    int errors = 0;
    int lat, rlow, drops, vseen;
    int inj_at = -1;
    logic              inj_v, inj_we;
    logic signed [7:0] inj_d, inj_c;
    logic [4:0]        inj_a;
    logic signed [7:0] y_obs;
    logic              sat_obs;

    fir_mac_seq dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_i(coef_i),
        .data_o(data_o), .valid_o(valid_o), .sat_o(sat_o), .drop_o(drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_i    = 8'(v);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Present one sample, optionally inject a stray strobe / coef write at cycle inj_at,
    // then wait (bounded) for the result.
    task automatic send(input logic signed [7:0] s);
        data_i  = s;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        coef_we = 1'b0;
        lat = 0; rlow = 0; drops = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) rlow++;
            if (drop_o) drops++;
            if (lat == inj_at) begin
                valid_i = inj_v; data_i = inj_d;
                coef_we = inj_we; coef_addr = inj_a; coef_i = inj_c;
            end else begin
                valid_i = 1'b0; coef_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        coef_we = 1'b0;
        inj_at  = -1;
        if (lat >= 100) check("timeout", lat, 18);
        y_obs   = data_o;
        sat_obs = sat_o;
    endtask

    task automatic ramp_coefs();
        for (int k = 0; k < 17; k++) load(k, k + 1);
    endtask

    task automatic impulse(input string tag);
        for (int i = 0; i < 17; i++) begin
            send(i == 0 ? 8'sd64 : 8'sd0);
            check({tag, "_y"}, y_obs, (i + 2) / 2);
            check({tag, "_sat"}, sat_obs, 0);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; data_i = '0; valid_i = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_i = '0;
        inj_v = 1'b0; inj_we = 1'b0; inj_d = '0; inj_c = '0; inj_a = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_drop", drop_o, 0);
        rst = 1'b1;
        @(negedge clk);

        ramp_coefs();
        send(8'sd64);
        check("lat", lat, 18);
        check("ready_low", rlow, 18);
        check("imp0_y", y_obs, 1);
        @(negedge clk);
        check("valid_1cyc", valid_o, 0);
        check("hold_y", data_o, 1);
        for (int i = 1; i < 17; i++) begin
            send(8'sd0);
            check("imp_y", y_obs, (i + 2) / 2);
            check("imp_sat", sat_obs, 0);
        end

        inj_at = 3; inj_v = 1'b1; inj_d = 8'sd50; inj_we = 1'b0;
        send(8'sd64);
        check("drop_cnt", drops, 1);
        check("drop_y0", y_obs, 1);
        send(8'sd0);
        check("drop_y1", y_obs, 1);

        pulse_rst();
        inj_at = 3; inj_v = 1'b0; inj_we = 1'b1; inj_a = 5'd1; inj_c = 8'sd127;
        send(8'sd100);
        check("cg_y0", y_obs, 0);
        load(17, 127);
        coef_we = 1'b1; coef_addr = 5'd0; coef_i = 8'sd1;
        send(8'sd100);
        check("cg_y1", y_obs, 1);
        check("cg_sat", sat_obs, 0);

        pulse_rst();
        for (int k = 0; k < 17; k++) load(k, 127);
        send(8'sd127);
        check("sat_first_y", y_obs, 126);
        check("sat_first_s", sat_obs, 0);
        for (int i = 1; i < 17; i++) send(8'sd127);
        check("sat_pos_y", y_obs, 127);
        check("sat_pos_s", sat_obs, 1);
        for (int i = 0; i < 17; i++) send(-8'sd128);
        check("sat_neg_y", y_obs, -128);
        check("sat_neg_s", sat_obs, 1);
        repeat (3) @(negedge clk);
        check("sat_hold_y", data_o, -128);
        check("sat_hold_s", sat_o, 1);

        data_i = 8'sd64; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_data", data_o, 0);
        check("mid_rst_sat", sat_o, 0);
        @(negedge clk);
        rst = 1'b1;
        vseen = 0;
        for (int i = 0; i < 25; i++) begin
            if (valid_o) vseen++;
            @(negedge clk);
        end
        check("mid_rst_novalid", vseen, 0);
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_data2", data_o, 0);
        ramp_coefs();
        impulse("imp2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
